// File: rtl/memx_ctrl_if.sv
// rtl/memx_ctrl_if.sv - host request/response and memory-model bus bundle for memx_ctrl
interface memx_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) ();
  logic              memx_rd_i;
  logic              memx_wr_i;
  logic [ADDR_W-1:0] memx_adr_i;
  logic [DATA_W-1:0] memx_wdt_i;
  logic              memx_busy_o;
  logic [DATA_W-1:0] memx_rdt_o;
  logic              memx_rvld_o;
  logic              memx_wok_o;
  logic              memx_werr_o;
  logic [ADDR_W-1:0] model_adr_o;
  logic [DATA_W-1:0] model_wdt_o;
  logic              model_wr_o;
  logic [DATA_W-1:0] model_rdt_i;

  modport slave (
    input  memx_rd_i, memx_wr_i, memx_adr_i, memx_wdt_i, model_rdt_i,
    output memx_busy_o, memx_rdt_o, memx_rvld_o, memx_wok_o, memx_werr_o,
    output model_adr_o, model_wdt_o, model_wr_o
  );

  modport master (
    output memx_rd_i, memx_wr_i, memx_adr_i, memx_wdt_i, model_rdt_i,
    input  memx_busy_o, memx_rdt_o, memx_rvld_o, memx_wok_o, memx_werr_o,
    input  model_adr_o, model_wdt_o, model_wr_o
  );
endinterface

// File: rtl/memx_ctrl.sv
// rtl/memx_ctrl.sv - timed read/write sequencer for a slow memory model, all outputs registered
// Define MEMX_WRITE_VERIFY_EN to add the read-back verify state with bounded write retries.
module memx_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int RD_DLY    = 5000,
  parameter int WR_DLY    = 750000,
  parameter int CNT_W     = 20,
  parameter int MAX_RETRY = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  memx_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_DLY - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_DLY - 1);

`ifdef MEMX_WRITE_VERIFY_EN
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_VF} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
`endif

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [ADDR_W-1:0] adr_q, adr_n;
  logic [DATA_W-1:0] wdt_q, wdt_n;
  logic [DATA_W-1:0] rdt_q, rdt_n;
  logic              mwr_q, mwr_n;
  logic              busy_q, busy_n;
  logic              rvld_q, rvld_n;
  logic              wok_q, wok_n;
`ifdef MEMX_WRITE_VERIFY_EN
  logic              werr_q, werr_n;
  logic [RTY_W-1:0]  rty_q, rty_n;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdt_q   <= '0;
      rdt_q   <= '0;
      mwr_q   <= 1'b0;
      busy_q  <= 1'b0;
      rvld_q  <= 1'b0;
      wok_q   <= 1'b0;
`ifdef MEMX_WRITE_VERIFY_EN
      werr_q  <= 1'b0;
      rty_q   <= '0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      adr_q   <= adr_n;
      wdt_q   <= wdt_n;
      rdt_q   <= rdt_n;
      mwr_q   <= mwr_n;
      busy_q  <= busy_n;
      rvld_q  <= rvld_n;
      wok_q   <= wok_n;
`ifdef MEMX_WRITE_VERIFY_EN
      werr_q  <= werr_n;
      rty_q   <= rty_n;
`endif
    end
  end

  // Every output is computed here one cycle ahead and registered above,
  // so completion pulses and busy fall land on the same edge.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    adr_n   = adr_q;
    wdt_n   = wdt_q;
    rdt_n   = rdt_q;
    mwr_n   = mwr_q;
    busy_n  = busy_q;
    rvld_n  = 1'b0;
    wok_n   = 1'b0;
`ifdef MEMX_WRITE_VERIFY_EN
    werr_n  = 1'b0;
    rty_n   = rty_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_n = '0;
        if (!busy_q && bus.memx_rd_i) begin
          state_n = S_RD;
          adr_n   = bus.memx_adr_i;
          busy_n  = 1'b1;
          mwr_n   = 1'b0;
        end else if (!busy_q && bus.memx_wr_i) begin
          state_n = S_WR;
          adr_n   = bus.memx_adr_i;
          wdt_n   = bus.memx_wdt_i;
          busy_n  = 1'b1;
          mwr_n   = 1'b1;
`ifdef MEMX_WRITE_VERIFY_EN
          rty_n   = '0;
`endif
        end
      end

      S_RD: begin
        if (cnt_q == RD_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          rdt_n   = bus.model_rdt_i;
          rvld_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      S_WR: begin
        if (cnt_q == WR_LAST) begin
          cnt_n = '0;
          mwr_n = 1'b0;
`ifdef MEMX_WRITE_VERIFY_EN
          state_n = S_VF;
`else
          state_n = S_IDLE;
          wok_n   = 1'b1;
          busy_n  = 1'b0;
`endif
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

`ifdef MEMX_WRITE_VERIFY_EN
      S_VF: begin
        if (cnt_q == RD_LAST) begin
          cnt_n = '0;
          if (bus.model_rdt_i == wdt_q) begin
            state_n = S_IDLE;
            wok_n   = 1'b1;
            busy_n  = 1'b0;
          end else if (rty_q == RTY_MAX) begin
            state_n = S_IDLE;
            werr_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n = S_WR;
            rty_n   = rty_q + 1'b1;
            mwr_n   = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
`endif

      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        mwr_n   = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.memx_busy_o = busy_q;
  assign bus.memx_rdt_o  = rdt_q;
  assign bus.memx_rvld_o = rvld_q;
  assign bus.memx_wok_o  = wok_q;
  assign bus.model_adr_o = adr_q;
  assign bus.model_wdt_o = wdt_q;
  assign bus.model_wr_o  = mwr_q;
`ifdef MEMX_WRITE_VERIFY_EN
  assign bus.memx_werr_o = werr_q;
`else
  assign bus.memx_werr_o = 1'b0;
`endif

endmodule

// File: tb/tb_memx_ctrl.sv
// tb/tb_memx_ctrl.sv - directed and random checks of memx_ctrl against a latency/result reference model
module tb_memx_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int RD  = 4;
  localparam int WR  = 8;
  localparam int RTY = 2;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;

  memx_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  memx_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .RD_DLY(RD), .WR_DLY(WR), .CNT_W(8), .MAX_RETRY(RTY)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: stores on each strobed cycle; override forces the read data.
  logic [DW-1:0] mem [1024];
  logic          mem_clr;
  logic          ovr_en;
  logic [DW-1:0] ovr_val;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (bus.model_wr_o) begin
      mem[bus.model_adr_o] <= bus.model_wdt_o;
    end
  end

  assign bus.model_rdt_i = ovr_en ? ovr_val : mem[bus.model_adr_o];

  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] last_rdt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge and check the whole operation.
  task automatic run_op(input string tag, input bit rd, input bit wr, input bit rd_hold,
                        input logic [AW-1:0] adr, input logic [DW-1:0] wdt,
                        input bit ovr, input logic [DW-1:0] oval);
    int exp_lat, exp_kind, exp_wrc, passes;
    int n, wrc, hold_bad, kind, npulse;
    bit done;
    logic [DW-1:0] exp_rdt;
    passes = 1;
    if (rd) begin
      exp_lat  = RD;
      exp_kind = 0;
      exp_wrc  = 0;
      exp_rdt  = ovr ? oval : ref_mem[adr];
    end else begin
`ifdef MEMX_WRITE_VERIFY_EN
      if (ovr && oval != wdt) passes = RTY + 1;
      exp_lat  = passes * (WR + RD);
      exp_wrc  = passes * WR;
      exp_kind = (passes > 1) ? 2 : 1;
`else
      exp_lat  = WR;
      exp_wrc  = WR;
      exp_kind = 1;
`endif
      exp_rdt     = last_rdt;
      ref_mem[adr] = wdt;
    end

    bus.memx_rd_i  = rd;
    bus.memx_wr_i  = wr;
    bus.memx_adr_i = adr;
    bus.memx_wdt_i = wdt;
    ovr_en  = ovr;
    ovr_val = oval;
    @(posedge clk);
    @(negedge clk);
    bus.memx_wr_i = 1'b0;
    bus.memx_rd_i = rd_hold;

    n = 1; done = 0; wrc = 0; hold_bad = 0; kind = -1; npulse = 0;
    while (!done && n <= 400) begin
      if (n == 2) bus.memx_rd_i = 1'b0;
      npulse = int'(bus.memx_rvld_o) + int'(bus.memx_wok_o) + int'(bus.memx_werr_o);
      if (npulse != 0) begin
        done = 1;
        kind = bus.memx_rvld_o ? 0 : (bus.memx_wok_o ? 1 : 2);
      end else begin
        if (bus.model_wr_o) wrc++;
        if (!bus.memx_busy_o || bus.model_adr_o !== adr || (!rd && bus.model_wdt_o !== wdt))
          hold_bad++;
        n++;
        @(negedge clk);
      end
    end

    check({tag, "_done"},   32'(done),            32'd1);
    check({tag, "_lat"},    32'(n - 1),           32'(exp_lat));
    check({tag, "_kind"},   32'(kind),            32'(exp_kind));
    check({tag, "_onehot"}, 32'(npulse),          32'd1);
    check({tag, "_busyend"},32'(bus.memx_busy_o), 32'd0);
    check({tag, "_rdt"},    32'(bus.memx_rdt_o),  32'(exp_rdt));
    check({tag, "_wrcyc"},  32'(wrc),             32'(exp_wrc));
    check({tag, "_hold"},   32'(hold_bad),        32'd0);
    if (rd) last_rdt = exp_rdt;

    ovr_en = 1'b0;
    @(negedge clk);
    check({tag, "_post"}, 32'({bus.memx_rvld_o, bus.memx_wok_o, bus.memx_werr_o, bus.memx_busy_o}), 32'd0);
  endtask

  initial begin
    int bad;
    tests = 0; fails = 0;
    rstn = 1'b0;
    mem_clr = 1'b1;
    ovr_en = 1'b0; ovr_val = '0;
    bus.memx_rd_i = 1'b0; bus.memx_wr_i = 1'b0;
    bus.memx_adr_i = '0; bus.memx_wdt_i = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    last_rdt = '0;

    #12;
    check("reset_outputs", 32'({bus.memx_busy_o, bus.memx_rvld_o, bus.memx_wok_o, bus.memx_werr_o,
                                bus.model_wr_o, bus.memx_rdt_o}), 32'd0);
    check("reset_model_bus", 32'({bus.model_adr_o, bus.model_wdt_o}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    rstn = 1'b1;

    // Read accepted on the first edge after reset release.
    run_op("rd_beef", 1'b1, 1'b0, 1'b0, 10'h155, 16'h0, 1'b1, 16'hBEEF);
    run_op("wr_ok",   1'b0, 1'b1, 1'b0, 10'h0A5, 16'h1234, 1'b0, 16'h0);
    run_op("rd_back", 1'b1, 1'b0, 1'b0, 10'h0A5, 16'h0, 1'b0, 16'h0);
    run_op("wr_fail", 1'b0, 1'b1, 1'b0, 10'h0A6, 16'h1234, 1'b1, 16'h0000);
    run_op("rd_wins", 1'b1, 1'b1, 1'b1, 10'h0A7, 16'h5555, 1'b0, 16'h0);
    run_op("rd_nowr", 1'b1, 1'b0, 1'b0, 10'h0A7, 16'h0, 1'b0, 16'h0);
    run_op("wr_00ff", 1'b0, 1'b1, 1'b0, 10'h010, 16'h00FF, 1'b0, 16'h0);

    // Reset during the fifth WR cycle abandons the write.
    bus.memx_wr_i = 1'b1; bus.memx_adr_i = 10'h0C3; bus.memx_wdt_i = 16'h5A5A;
    @(posedge clk);
    @(negedge clk);
    bus.memx_wr_i = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pre_wr", 32'(bus.model_wr_o), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_outs", 32'({bus.memx_busy_o, bus.memx_rvld_o, bus.memx_wok_o, bus.memx_werr_o,
                                 bus.model_wr_o, bus.memx_rdt_o}), 32'd0);
    check("rst_async_bus", 32'({bus.model_adr_o, bus.model_wdt_o}), 32'd0);
    ref_mem[10'h0C3] = 16'h5A5A;
    last_rdt = '0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.memx_wok_o || bus.memx_werr_o || bus.memx_rvld_o || bus.model_wr_o) bad++;
    end
    rstn = 1'b1;
    run_op("rd_after_rst", 1'b1, 1'b0, 1'b0, 10'h0C3, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.memx_wok_o || bus.memx_werr_o || bus.memx_rvld_o || bus.memx_busy_o) bad++;
    end
    check("rst_no_stray", 32'(bad), 32'd0);

    // Random mix over a small address window so reads hit written data.
    for (int i = 0; i < 16; i++) begin
      int sel;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      sel = $urandom_range(0, 2);
      a   = AW'($urandom_range(0, 15));
      d   = DW'($urandom) | 16'h0001;
      if (sel == 0)
        run_op("rnd_rd", 1'b1, 1'($urandom_range(0, 1)), 1'b0, a, d, 1'b0, 16'h0);
      else if (sel == 1)
        run_op("rnd_wr", 1'b0, 1'b1, 1'b0, a, d, 1'b0, 16'h0);
      else
        run_op("rnd_wrbad", 1'b0, 1'b1, 1'b0, a, d, 1'b1, d ^ 16'h8001);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memx_ctrl.md
MEMX_CTRL -- requirements
Module: memx_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data width.
REQ-002 Parameter ADDR_W, default 10, SHALL set the address width.
REQ-003 Parameter RD_DLY, default 5000, SHALL set the model read access time in cycles; minimum 1.
REQ-004 Parameter WR_DLY, default 750000, SHALL set the model write time in cycles; minimum 1.
REQ-005 Parameter CNT_W, default 20, SHALL set the delay counter width and SHALL hold max(RD_DLY, WR_DLY).
REQ-006 Parameter MAX_RETRY, default 2, SHALL set the number of write re-attempts after a verify mismatch.
REQ-007 Ports SHALL be:
  clk_i  in  1  clock, rising edge; the block's only clock
  rstn_i  in  1  reset, asynchronous, active-low
  memx_rd_i  in  1  read request, level
  memx_wr_i  in  1  write request, level
  memx_adr_i  in  ADDR_W  request address
  memx_wdt_i  in  DATA_W  write data
  memx_busy_o  out  1  operation in progress
  memx_rdt_o  out  DATA_W  read data, held until the next read completes
  memx_rvld_o  out  1  read data valid, 1-cycle pulse
  memx_wok_o  out  1  write succeeded, 1-cycle pulse
  memx_werr_o  out  1  write failed after retries, 1-cycle pulse
  model_adr_o  out  ADDR_W  memory model address
  model_wdt_o  out  DATA_W  memory model write data
  model_wr_o  out  1  memory model write strobe, level
  model_rdt_i  in  DATA_W  memory model read data

Function
REQ-008 The FSM SHALL have the states IDLE, RD, WR and VF; all outputs SHALL be registered.
REQ-009 In IDLE with memx_busy_o=0, a request SHALL be accepted at the clock edge.
REQ-010 At acceptance, the address (and the write data on a write) SHALL be captured; model_adr_o and model_wdt_o SHALL hold those values for the whole operation.
REQ-011 If memx_rd_i and memx_wr_i are both high in IDLE, the read SHALL win; the write SHALL be dropped.
REQ-012 Requests arriving while memx_busy_o=1 SHALL be ignored; there is no queue.
REQ-013 memx_busy_o SHALL rise on the acceptance edge and fall on the edge that pulses rvld, wok or werr.
REQ-014 RD: model_wr_o=0 for RD_DLY cycles. On the final cycle's edge, model_rdt_i SHALL load memx_rdt_o, memx_rvld_o SHALL pulse, and the FSM SHALL return to IDLE.
REQ-015 WR: model_wr_o=1 for exactly WR_DLY cycles, then the FSM SHALL move to VF (macro defined) or complete (macro undefined).
REQ-016 VF: model_wr_o=0 for RD_DLY cycles. On the final cycle, model_rdt_i SHALL be compared with the captured write data.
REQ-017 On a VF match: memx_wok_o SHALL pulse and the FSM SHALL return to IDLE.
REQ-018 On a VF mismatch with retry count < MAX_RETRY: the retry count SHALL increment and the FSM SHALL re-enter WR.
REQ-019 On a VF mismatch with retry count = MAX_RETRY: memx_werr_o SHALL pulse and the FSM SHALL return to IDLE.
REQ-020 The delay counter SHALL clear on every state entry and SHALL never wrap within a state. The retry count SHALL clear on acceptance.
REQ-021 memx_rvld_o, memx_wok_o and memx_werr_o SHALL be mutually exclusive and each SHALL be high for exactly one cycle.
REQ-022 Accepted latency: read = RD_DLY cycles; write = (k+1)*(WR_DLY+RD_DLY) cycles with verify (k = retries used), WR_DLY without verify.

Reset
REQ-023 rstn_i low SHALL asynchronously force state IDLE, counter 0, retry count 0, and all outputs 0.
REQ-024 Reset mid-operation SHALL abandon the operation: model_wr_o drops immediately, and no rvld, wok or werr pulse is issued for it.
REQ-025 After rstn_i deasserts, a request SHALL be accepted on the first clock edge.

Configuration
REQ-026 With MEMX_WRITE_VERIFY_EN defined, the VF state and the retry logic SHALL be present.
REQ-027 With MEMX_WRITE_VERIFY_EN undefined, VF and the retry logic SHALL be absent, memx_werr_o SHALL be tied to 0, and memx_wok_o SHALL pulse at the end of WR.

Verification (RD_DLY=4, WR_DLY=8, MAX_RETRY=2)
REQ-028 Read of 0x155, model returns 0xBEEF -> busy for 4 cycles, memx_rvld_o pulses with memx_rdt_o=0xBEEF, model_wr_o stays 0.
REQ-029 Write 0x1234 to 0x0A5, model echoes it -> model_wr_o high for 8 cycles, then 4 verify cycles; memx_wok_o pulses 12 cycles after acceptance.
REQ-030 Write 0x1234, model returns 0x0000 -> three WR/VF passes; memx_werr_o pulses 36 cycles after acceptance; wok never pulses.
REQ-031 rd and wr asserted together in IDLE -> only the read executes; a further rd during busy is ignored (exactly one rvld pulse).
REQ-032 rstn_i low during cycle 5 of WR -> model_wr_o=0 and all outputs 0 immediately; no wok; a new read after release completes normally.
REQ-033 MEMX_WRITE_VERIFY_EN undefined, write 0x00FF -> memx_wok_o pulses 8 cycles after acceptance; no verify phase.
